// File: rtl/traffic_xing_ctrl_if.sv
// Lamp/request bundle for traffic_xing_ctrl.
// The master drives enable, night and pedestrian requests. The slave (the controller) drives the lamps, walk signals and phase.
interface traffic_xing_ctrl_if #(
  parameter int unsigned N_DIR = 2
);
  localparam int unsigned PH_W = $clog2(N_DIR);

  logic             en_i;
  logic             night_i;
  logic [N_DIR-1:0] ped_req_i;
  logic [N_DIR-1:0] red_o;
  logic [N_DIR-1:0] yellow_o;
  logic [N_DIR-1:0] green_o;
  logic [N_DIR-1:0] ped_walk_o;
  logic [PH_W-1:0]  phase_o;

  modport master (
    output en_i, night_i, ped_req_i,
    input  red_o, yellow_o, green_o, ped_walk_o, phase_o
  );

  modport slave (
    input  en_i, night_i, ped_req_i,
    output red_o, yellow_o, green_o, ped_walk_o, phase_o
  );
endinterface

// File: rtl/traffic_xing_ctrl.sv
// Round-robin N_DIR-approach traffic-light controller.
// It adds all-red clearance, latched pedestrian walk requests, a night blink mode and a run/hold enable.
module traffic_xing_ctrl #(
  parameter int unsigned N_DIR      = 2,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned RY_CYC     = 2,
  parameter int unsigned GREEN_CYC  = 6,
  parameter int unsigned BLINK_CYC  = 4,
  parameter int unsigned BLINK_HALF = 1,
  parameter int unsigned YELLOW_CYC = 3,
  parameter int unsigned ALLRED_CYC = 2,
  parameter int unsigned NIGHT_HALF = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  traffic_xing_ctrl_if.slave bus
);
  localparam int unsigned PH_W = $clog2(N_DIR);

  typedef enum logic [2:0] {
    S_ALL_RED, S_RED_YELLOW, S_GREEN, S_GREEN_BLINK, S_YELLOW, S_NIGHT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             blink_q, blink_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [N_DIR-1:0] pend_q, pend_d;
  logic [N_DIR-1:0] walk_q, walk_d;
  logic [N_DIR-1:0] red_q, red_d;
  logic [N_DIR-1:0] yellow_q, yellow_d;
  logic [N_DIR-1:0] green_q, green_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    blink_d  = blink_q;
    phase_d  = phase_q;
    walk_d   = walk_q;
    red_d    = red_q;
    yellow_d = yellow_q;
    green_d  = green_q;
    // Requests latch even while held.
    pend_d   = pend_q | bus.ped_req_i;

    if (bus.en_i) begin
      case (state_q)
        S_ALL_RED: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (bus.night_i) begin
            state_d = S_NIGHT;
            blink_d = 1'b1;
            hcnt_d  = CNT_W'(NIGHT_HALF - 1);
          end else begin
            state_d = S_RED_YELLOW;
            cnt_d   = CNT_W'(RY_CYC - 1);
          end
        end
        S_RED_YELLOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d         = S_GREEN;
            cnt_d           = CNT_W'(GREEN_CYC - 1);
            walk_d          = '0;
            walk_d[phase_q] = pend_d[phase_q];
            pend_d[phase_q] = 1'b0;
          end
        end
        S_GREEN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = S_GREEN_BLINK;
            cnt_d   = CNT_W'(BLINK_CYC - 1);
            blink_d = 1'b0;
            hcnt_d  = CNT_W'(BLINK_HALF - 1);
            walk_d  = '0;
          end
        end
        S_GREEN_BLINK: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (hcnt_q == '0) begin
              blink_d = ~blink_q;
              hcnt_d  = CNT_W'(BLINK_HALF - 1);
            end else begin
              hcnt_d = hcnt_q - CNT_W'(1);
            end
          end else begin
            state_d = S_YELLOW;
            cnt_d   = CNT_W'(YELLOW_CYC - 1);
          end
        end
        S_YELLOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = S_ALL_RED;
            cnt_d   = CNT_W'(ALLRED_CYC - 1);
            phase_d = (phase_q == PH_W'(N_DIR - 1)) ? '0 : phase_q + PH_W'(1);
          end
        end
        S_NIGHT: begin
          if (!bus.night_i) begin
            state_d = S_ALL_RED;
            cnt_d   = CNT_W'(ALLRED_CYC - 1);
            phase_d = '0;
          end else if (hcnt_q == '0) begin
            blink_d = ~blink_q;
            hcnt_d  = CNT_W'(NIGHT_HALF - 1);
          end else begin
            hcnt_d = hcnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = S_ALL_RED;
          cnt_d   = CNT_W'(ALLRED_CYC - 1);
        end
      endcase

      // Lamps are decoded from the next state so that the outputs leave the flops already aligned with the state.
      red_d    = '1;
      yellow_d = '0;
      green_d  = '0;
      case (state_d)
        S_RED_YELLOW: yellow_d[phase_d] = 1'b1;
        S_GREEN: begin
          red_d[phase_d]   = 1'b0;
          green_d[phase_d] = 1'b1;
        end
        S_GREEN_BLINK: begin
          red_d[phase_d]   = 1'b0;
          green_d[phase_d] = blink_d;
        end
        S_YELLOW: begin
          red_d[phase_d]    = 1'b0;
          yellow_d[phase_d] = 1'b1;
        end
        S_NIGHT: begin
          red_d    = '0;
          yellow_d = {N_DIR{blink_d}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_ALL_RED;
      cnt_q    <= CNT_W'(ALLRED_CYC - 1);
      hcnt_q   <= '0;
      blink_q  <= 1'b0;
      phase_q  <= '0;
      pend_q   <= '0;
      walk_q   <= '0;
      red_q    <= '1;
      yellow_q <= '0;
      green_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
      walk_q   <= walk_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
    end
  end

  assign bus.red_o      = red_q;
  assign bus.yellow_o   = yellow_q;
  assign bus.green_o    = green_q;
  assign bus.ped_walk_o = walk_q;
  assign bus.phase_o    = phase_q;
endmodule

// File: tb/tb_traffic_xing_ctrl.sv
// Directed bench for traffic_xing_ctrl with default parameters and two approaches.
// Every sample is compared against hand-derived lamp patterns.
module tb_traffic_xing_ctrl;
  localparam int ST_AR = 0, ST_RY = 1, ST_G = 2, ST_BOFF = 3, ST_BON = 4,
                 ST_Y = 5, ST_NON = 6, ST_NOFF = 7;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   g0_cyc = -1;

  traffic_xing_ctrl_if #(.N_DIR(2)) bus ();

  traffic_xing_ctrl #(.N_DIR(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // {red, yellow, green, walk, phase}
  function automatic logic [8:0] lv(input int st, input int p, input logic [1:0] w, input int ph);
    logic [1:0] r, y, g, wk;
    r = 2'b11; y = 2'b00; g = 2'b00; wk = 2'b00;
    case (st)
      ST_RY:   y[p] = 1'b1;
      ST_G:    begin r[p] = 1'b0; g[p] = 1'b1; wk = w; end
      ST_BOFF: r[p] = 1'b0;
      ST_BON:  begin r[p] = 1'b0; g[p] = 1'b1; end
      ST_Y:    begin r[p] = 1'b0; y[p] = 1'b1; end
      ST_NON:  begin r = 2'b00; y = 2'b11; end
      ST_NOFF: r = 2'b00;
      default: ;
    endcase
    return {r, y, g, wk, ph[0]};
  endfunction

  function automatic logic [8:0] obs();
    return {bus.red_o, bus.yellow_o, bus.green_o, bus.ped_walk_o, bus.phase_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
    cyc++;
  endtask

  // One full approach: RY x2, G x6, blink x4, Y x3, then all-red x2 with the next phase.
  task automatic approach(input int p, input logic [1:0] w, input int req_i = -1,
                          input logic [1:0] req_m = 2'b00, input int night_at = -1,
                          input int hold_at = -1, input int rst_at = -1);
    for (int i = 0; i < 17; i++) begin
      int st;
      int ph;
      logic [1:0] ww;
      tick();
      ph = p;
      ww = 2'b00;
      if (i < 2) st = ST_RY;
      else if (i < 8) begin st = ST_G; ww = w; end
      else if (i < 12) st = (((i - 8) % 2) == 0) ? ST_BOFF : ST_BON;
      else if (i < 15) st = ST_Y;
      else begin st = ST_AR; ph = (p + 1) % 2; end
      check($sformatf("p%0d_i%0d", p, i), obs(), lv(st, p, ww, ph));
      if (i == 2 && p == 0) begin
        if (g0_cyc >= 0) check("g0_period", cyc - g0_cyc, 34);
        g0_cyc = cyc;
      end
      bus.ped_req_i = (i == req_i) ? req_m : 2'b00;
      if (i == night_at) bus.night_i = 1'b1;
      if (i == hold_at) begin
        bus.en_i = 1'b0;
        bus.ped_req_i = 2'b10;
        for (int k = 0; k < 5; k++) begin
          tick();
          check($sformatf("hold%0d", k), obs(), lv(st, p, ww, ph));
          bus.ped_req_i = 2'b00;
        end
        bus.en_i = 1'b1;
      end
      if (i == rst_at) begin
        #4;
        rst_i = 1'b1;
        #1;
        check("rst_async", obs(), lv(ST_AR, 0, 2'b00, 0));
        #1;
        rst_i = 1'b0;
        bus.ped_req_i = 2'b00;
        return;
      end
    end
  endtask

  initial begin
    bus.en_i      = 1'b1;
    bus.night_i   = 1'b0;
    bus.ped_req_i = 2'b00;
    #17;
    check("reset", obs(), lv(ST_AR, 0, 2'b00, 0));
    #5;
    rst_i = 1'b0;
    tick();
    check("ar_start", obs(), lv(ST_AR, 0, 2'b00, 0));

    approach(0, 2'b00);
    approach(1, 2'b00);

    // Request for approach 1 raised during approach 0 green.
    approach(0, 2'b00, 4, 2'b10);
    approach(1, 2'b10);

    // A request raised mid-green waits for that approach's next green.
    approach(0, 2'b00, 5, 2'b01);
    approach(1, 2'b00);
    approach(0, 2'b01);
    approach(1, 2'b00);

    // A request on the green-entry edge is served in that same green.
    approach(0, 2'b00);
    approach(1, 2'b10, 1, 2'b10);
    approach(0, 2'b00);
    approach(1, 2'b00);

    approach(0, 2'b00, -1, 2'b00, 4);
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("night%0d", k), obs(),
            lv((((k / 4) % 2) == 0) ? ST_NON : ST_NOFF, 0, 2'b00, 1));
    end
    bus.night_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("night_ar%0d", k), obs(), lv(ST_AR, 0, 2'b00, 0));
    end
    g0_cyc = -1;
    approach(0, 2'b00);
    approach(1, 2'b00);

    approach(0, 2'b00, -1, 2'b00, -1, 4);
    g0_cyc = -1;
    approach(1, 2'b10);

    // Both requests are pending when the reset hits, so walk must stay low afterwards.
    approach(0, 2'b00, 4, 2'b11, -1, -1, 9);
    g0_cyc = -1;
    tick();
    check("ar_after_rst", obs(), lv(ST_AR, 0, 2'b00, 0));
    approach(0, 2'b00);
    approach(1, 2'b00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
